// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// State encoding, Booth codes and the per-state strobe decode.
package mul_pkg;

  localparam int MUL_W = 19;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    TEST,
    ADD,
    SUB,
    SHIFT,
    DONE
  } mul_state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic ld_m;
    logic ld_q;
    logic clr_a;
    logic ld_a;
    logic alu_sub;
    logic shift;
  } mul_ctl_t;

  // Moore decode: every strobe is a pure function of the state.
  function automatic mul_ctl_t ctl_decode(input mul_state_t s);
    mul_ctl_t c;
    c = '0;
    c.busy = (s != IDLE);
    unique case (s)
      INIT: begin
        c.ld_m  = 1'b1;
        c.ld_q  = 1'b1;
        c.clr_a = 1'b1;
      end
      ADD: c.ld_a = 1'b1;
      SUB: begin
        c.ld_a    = 1'b1;
        c.alu_sub = 1'b1;
      end
      SHIFT: c.shift = 1'b1;
      DONE:  c.done  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_mul_ctrl_iter_cnt.sv
// Iteration counter for the Booth sequencer.
// Synchronous clear, increment enable, terminal count at W-1.
module iter_cnt #(
  parameter int W  = 19,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequencing FSM for the radix-2 Booth sequential multiplier.
// Walks INIT, TEST, ADD/SUB, SHIFT per bit and pulses done.
module booth_mul_ctrl
  import mul_pkg::*;
#(
  parameter int W  = MUL_W,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          q0,
  input  logic          q_m1,
  output logic          busy,
  output logic          done,
  output logic          ld_m,
  output logic          ld_q,
  output logic          clr_a,
  output logic          ld_a,
  output logic          alu_sub,
  output logic          shift,
  output logic [CW-1:0] cnt
);

  mul_state_t state;
  mul_state_t nxt;
  mul_ctl_t   ctl;
  logic       tc;
  logic       cnt_clr;
  logic       cnt_inc;

  assign cnt_clr = rst | (state == INIT);
  assign cnt_inc = (state == SHIFT) & ~tc;

  iter_cnt #(
    .W  (W),
    .CW (CW)
  ) u_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = INIT;
      INIT:  nxt = TEST;
      TEST: begin
        unique case ({q0, q_m1})
          BOOTH_ADD: nxt = ADD;
          BOOTH_SUB: nxt = SUB;
          default:   nxt = SHIFT;
        endcase
      end
      ADD:   nxt = SHIFT;
      SUB:   nxt = SHIFT;
      SHIFT: nxt = tc ? DONE : TEST;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= ctl_decode(nxt);
    end
  end

  assign busy    = ctl.busy;
  assign done    = ctl.done;
  assign ld_m    = ctl.ld_m;
  assign ld_q    = ctl.ld_q;
  assign clr_a   = ctl.clr_a;
  assign ld_a    = ctl.ld_a;
  assign alu_sub = ctl.alu_sub;
  assign shift   = ctl.shift;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl against a per-iteration timeline model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_booth_mul_ctrl;

  localparam int W  = 19;
  localparam int CW = $clog2(W);

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_INIT  = 8'b1011_1000;
  localparam logic [7:0] C_TEST  = 8'b1000_0000;
  localparam logic [7:0] C_ADD   = 8'b1000_0100;
  localparam logic [7:0] C_SUB   = 8'b1000_0110;
  localparam logic [7:0] C_SHIFT = 8'b1000_0001;
  localparam logic [7:0] C_DONE  = 8'b1100_0000;

  logic          clk = 1'b0;
  logic          rst, start, q0, q_m1;
  logic          busy, done, ld_m, ld_q, clr_a, ld_a, alu_sub, shift;
  logic [CW-1:0] cnt;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [7:0] ctl;
    int         cnt;
    logic       cnt_chk;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  booth_mul_ctrl #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .q0      (q0),
    .q_m1    (q_m1),
    .busy    (busy),
    .done    (done),
    .ld_m    (ld_m),
    .ld_q    (ld_q),
    .clr_a   (clr_a),
    .ld_a    (ld_a),
    .alu_sub (alu_sub),
    .shift   (shift),
    .cnt     (cnt)
  );

  function automatic logic [7:0] obs();
    return {busy, done, ld_m, ld_q, clr_a, ld_a, alu_sub, shift};
  endfunction

  // Expected cycle-by-cycle timeline from cycle 1 through DONE.
  function automatic void build(input logic [1:0] codes[W]);
    exp_q.delete();
    exp_q.push_back('{C_INIT, 0, 1'b0, 2'b00});
    for (int i = 0; i < W; i++) begin
      exp_q.push_back('{C_TEST, i, 1'b1, codes[i]});
      if (codes[i] == 2'b01) exp_q.push_back('{C_ADD, i, 1'b1, codes[i]});
      if (codes[i] == 2'b10) exp_q.push_back('{C_SUB, i, 1'b1, codes[i]});
      exp_q.push_back('{C_SHIFT, i, 1'b1, codes[i]});
    end
    exp_q.push_back('{C_DONE, W - 1, 1'b1, 2'b00});
  endfunction

  // Entered on a falling edge of an IDLE cycle (cycle 0); ends on the
  // falling edge of the IDLE cycle after DONE.
  task automatic run_trace(input string nm, input logic [1:0] codes[W],
                           input int s0, input int s1);
    exp_t e;
    build(codes);
    start = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      e = exp_q[c-1];
      total++;
      if (obs() !== e.ctl)
        $display("FAIL %s ctl cyc %0d got %b exp %b", nm, c, obs(), e.ctl);
      else pass_cnt++;
      if (e.cnt_chk) begin
        total++;
        if (int'(cnt) !== e.cnt)
          $display("FAIL %s cnt cyc %0d got %0d exp %0d", nm, c, cnt, e.cnt);
        else pass_cnt++;
      end
      start = (c == s0) || (c == s1);
      {q0, q_m1} = e.code;
    end
    @(negedge clk);
    total++;
    if (obs() !== C_IDLE)
      $display("FAIL %s idle_after got %b exp %b", nm, obs(), C_IDLE);
    else pass_cnt++;
    start = 1'b0;
    {q0, q_m1} = 2'b00;
  endtask

  task automatic test_reset();
    logic [1:0] cd[W];
    rst = 1'b1; start = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== C_IDLE || cnt !== '0)
      $display("FAIL por got %b cnt %0d exp %b cnt 0", obs(), cnt, C_IDLE);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      {q0, q_m1} = 2'($urandom_range(0, 3));
      if (c >= 11) begin
        total++;
        if (obs() !== C_IDLE || cnt !== '0)
          $display("FAIL mid_rst cyc %0d got %b cnt %0d exp %b cnt 0",
                   c, obs(), cnt, C_IDLE);
        else pass_cnt++;
      end
      rst = (c == 10) || (c == 11);
    end
    {q0, q_m1} = 2'b00;
    foreach (cd[i]) cd[i] = 2'b00;
    run_trace("after_rst", cd, -1, -1);
  endtask

  task automatic test_hold();
    logic [1:0] cd[W];
    logic [1:0] pat[4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    foreach (pat[p]) begin
      foreach (cd[i]) cd[i] = pat[p];
      run_trace($sformatf("hold_%b", pat[p]), cd, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cd[W];
    foreach (cd[i]) cd[i] = (i % 2 == 0) ? 2'b01 : 2'b00;
    run_trace("alt", cd, 5, 50);
    foreach (cd[i]) cd[i] = 2'($urandom_range(0, 3));
    run_trace("b2b", cd, -1, -1);
  endtask

  task automatic test_rst_start();
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== C_IDLE)
      $display("FAIL rst_start got %b exp %b", obs(), C_IDLE);
    else pass_cnt++;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== C_IDLE)
      $display("FAIL rst_start_next got %b exp %b", obs(), C_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [1:0] cd[W];
    for (int r = 0; r < 4; r++) begin
      foreach (cd[i]) cd[i] = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_trace($sformatf("rand%0d", r), cd, $urandom_range(2, 30), -1);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_back_to_back();
    test_rst_start();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
